paddle_ctrl: RTL and testbench

//  Converts two raw player push-buttons into a clamped paddle row position for one side of the pong field.

---
 rtl/pong_pkg.sv | 51 +++++
 rtl/paddle_ctrl_debounce.sv | 46 ++++
 rtl/paddle_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_paddle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong-field constants, types and row arithmetic helpers.
// Used by paddle_ctrl and its debounce sub-module.
package pong_pkg;

   localparam int HEIGHT       = 16;
   localparam int PADDLE_LEN   = 3;
   localparam int PADDLE_MAX   = HEIGHT - PADDLE_LEN;
   localparam int ROW_W        = $clog2(HEIGHT);
   localparam int DEBOUNCE_TCK = 8;
   localparam int REPEAT_DLY   = 250;
   localparam int REPEAT_TCK   = 60;
   localparam int IDLE_TCK     = 2000;
   localparam int DEB_W        = $clog2(DEBOUNCE_TCK + 1);
   localparam int RCNT_W       = $clog2(REPEAT_DLY + 1);
   localparam int IDLE_W       = $clog2(IDLE_TCK);

   typedef logic [ROW_W-1:0]  row_t;
   typedef logic [RCNT_W-1:0] rcnt_t;
   typedef logic signed [1:0] dir_t;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} paddle_state_t;

   localparam dir_t DIR_NONE = 2'sb00;
   localparam dir_t DIR_DOWN = 2'sb01;
   localparam dir_t DIR_UP   = 2'sb11;

   localparam row_t PADDLE_HOME = row_t'(PADDLE_MAX / 2);

   // One-row move with saturation at both field edges; never wraps.
   function automatic row_t step_row(input row_t p, input dir_t d);
      logic signed [ROW_W:0] s;
      s = $signed({1'b0, p}) + (ROW_W+1)'(d);
      if (s[ROW_W])
         step_row = '0;
      else if (s > (ROW_W+1)'(PADDLE_MAX))
         step_row = row_t'(PADDLE_MAX);
      else
         step_row = s[ROW_W-1:0];
   endfunction

   // Top row that centres the paddle on the ball, clamped to the legal range.
   function automatic row_t track_target(input row_t ball);
      if (ball < row_t'(PADDLE_LEN / 2))
         track_target = '0;
      else if ((ball - row_t'(PADDLE_LEN / 2)) > row_t'(PADDLE_MAX))
         track_target = row_t'(PADDLE_MAX);
      else
         track_target = ball - row_t'(PADDLE_LEN / 2);
   endfunction

endpackage

// File: rtl/paddle_ctrl_debounce.sv
// Button synchroniser plus tick-gated debouncer; a new level is accepted after
// DEBOUNCE_TCK consecutive ticks of disagreement with the current accepted level.
module debounce
   import pong_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   output logic level,
   output logic level_next
);

   logic             sync_a;
   logic             sync_b;
   logic [DEB_W-1:0] cnt;
   logic             accept;

   assign accept = tick && (sync_b != level) && (cnt == DEB_W'(DEBOUNCE_TCK - 1));

   // level_next lets the paddle FSM act on the very tick a press is accepted.
   assign level_next = accept ? sync_b : level;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         if (tick) begin
            if (sync_b == level) begin
               cnt <= '0;
            end else if (accept) begin
               level <= sync_b;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/paddle_ctrl.sv
// Two-button paddle controller: debounce, hold/auto-repeat FSM, clamped row, hit flag.
// Optional ball-tracking autoplay is compiled in when PADDLE_AUTOPLAY_EN is defined.
module paddle_ctrl
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic [3:0] ball_y,
   output logic [3:0] pos,
   output logic       hit,
   output logic       auto
);

   logic          up_level;
   logic          up_next;
   logic          down_level;
   logic          down_next;
   dir_t          dir;
   logic          press;

   paddle_state_t state;
   paddle_state_t state_next;
   rcnt_t         cnt;
   rcnt_t         cnt_next;
   dir_t          last_dir;
   dir_t          last_dir_next;
   logic          manual_step;
   row_t          pos_next;

   debounce u_deb_up (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .raw        (btn_up),
      .level      (up_level),
      .level_next (up_next)
   );

   debounce u_deb_down (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .raw        (btn_down),
      .level      (down_level),
      .level_next (down_next)
   );

   // Both buttons held cancel out and behave exactly like neither.
   always_comb begin
      dir = DIR_NONE;
      if (up_next && !down_next)
         dir = DIR_UP;
      else if (down_next && !up_next)
         dir = DIR_DOWN;
   end

   assign press = tick & ((up_next & ~up_level) | (down_next & ~down_level));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         cnt      <= '0;
         last_dir <= DIR_NONE;
         pos      <= PADDLE_HOME;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         last_dir <= last_dir_next;
         pos      <= pos_next;
      end
   end

   // A direction reversal restarts the initial hold delay rather than repeating.
   always_comb begin
      state_next    = state;
      cnt_next      = cnt;
      last_dir_next = last_dir;
      manual_step   = 1'b0;
      if (tick) begin
         case (state)
            IDLE: begin
               if (dir != DIR_NONE) begin
                  manual_step   = 1'b1;
                  cnt_next      = rcnt_t'(REPEAT_DLY);
                  last_dir_next = dir;
                  state_next    = HOLD;
               end
            end
            HOLD, REPEAT: begin
               if (dir == DIR_NONE) begin
                  state_next = IDLE;
               end else if (dir != last_dir) begin
                  manual_step   = 1'b1;
                  cnt_next      = rcnt_t'(REPEAT_DLY);
                  last_dir_next = dir;
                  state_next    = HOLD;
               end else if (cnt == rcnt_t'(1)) begin
                  manual_step = 1'b1;
                  cnt_next    = rcnt_t'(REPEAT_TCK);
                  state_next  = REPEAT;
               end else begin
                  cnt_next = cnt - 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

`ifdef PADDLE_AUTOPLAY_EN
   logic              auto_on;
   logic [IDLE_W-1:0] idle_cnt;
   rcnt_t             track_cnt;
   logic              take;
   logic              auto_step;
   dir_t              auto_dir;
   row_t              target;

   assign take      = press | manual_step;
   assign auto_step = tick & auto_on & ~take & (track_cnt == rcnt_t'(1));
   assign target    = track_target(ball_y);
   assign auto      = auto_on;

   always_comb begin
      auto_dir = DIR_NONE;
      if (pos < target)
         auto_dir = DIR_DOWN;
      else if (pos > target)
         auto_dir = DIR_UP;
   end

   // Any player action hands control straight back and restarts the idle wait.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         auto_on   <= 1'b0;
         idle_cnt  <= '0;
         track_cnt <= rcnt_t'(REPEAT_TCK);
      end else if (tick) begin
         if (take) begin
            auto_on   <= 1'b0;
            idle_cnt  <= '0;
            track_cnt <= rcnt_t'(REPEAT_TCK);
         end else if (auto_on) begin
            if (track_cnt == rcnt_t'(1))
               track_cnt <= rcnt_t'(REPEAT_TCK);
            else
               track_cnt <= track_cnt - 1'b1;
         end else if (state == IDLE) begin
            if (idle_cnt == IDLE_W'(IDLE_TCK - 1)) begin
               auto_on   <= 1'b1;
               idle_cnt  <= '0;
               track_cnt <= rcnt_t'(REPEAT_TCK);
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end
`else
   assign auto = 1'b0;
`endif

   always_comb begin
      pos_next = pos;
      if (manual_step)
         pos_next = step_row(pos, dir);
`ifdef PADDLE_AUTOPLAY_EN
      else if (auto_step)
         pos_next = step_row(pos, auto_dir);
`endif
   end

   // pos+PADDLE_LEN-1 never exceeds HEIGHT-1, so the 4-bit sum cannot overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         hit <= 1'b0;
      else
         hit <= (ball_y >= pos) && (ball_y <= pos + row_t'(PADDLE_LEN - 1));
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl against a tick-level behavioural model.
// Autoplay scenario runs only when PADDLE_AUTOPLAY_EN is defined.
module tb_paddle_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       tick;
   logic       btn_up;
   logic       btn_down;
   logic [3:0] ball_y;
   logic [3:0] pos;
   logic       hit;
   logic       auto;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: accepted button levels, run lengths, paddle row, hold age.
   int m_up, m_dn, m_up_run, m_dn_run;
   int m_pos, m_prev_pos, m_held, m_ldir;
   int m_auto, m_idle, m_since;

   always #5 clk = ~clk;

   paddle_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .btn_up   (btn_up),
      .btn_down (btn_down),
      .ball_y   (ball_y),
      .pos      (pos),
      .hit      (hit),
      .auto     (auto)
   );

   function automatic logic exp_hit(input int p, input int b);
      return (b >= p) && (b <= p + 2);
   endfunction

   function automatic int clamp_row(input int v);
      if (v < 0) return 0;
      if (v > 13) return 13;
      return v;
   endfunction

   task automatic model_reset();
      m_up = 0; m_dn = 0; m_up_run = 0; m_dn_run = 0;
      m_pos = 6; m_prev_pos = 6; m_held = -1; m_ldir = 0;
      m_auto = 0; m_idle = 0; m_since = 0;
   endtask

   // Steps once at acceptance, again after 250 ticks held, then every 60.
   task automatic model_tick();
      int prev_up, prev_dn, dir, press, idle_before, manual, tgt;
      prev_up = m_up;
      prev_dn = m_dn;
      if (int'(btn_up) != m_up) begin
         m_up_run++;
         if (m_up_run == 8) begin m_up = int'(btn_up); m_up_run = 0; end
      end else m_up_run = 0;
      if (int'(btn_down) != m_dn) begin
         m_dn_run++;
         if (m_dn_run == 8) begin m_dn = int'(btn_down); m_dn_run = 0; end
      end else m_dn_run = 0;
      press = ((m_up == 1 && prev_up == 0) || (m_dn == 1 && prev_dn == 0)) ? 1 : 0;
      dir = (m_up == 1 && m_dn == 0) ? -1 : ((m_dn == 1 && m_up == 0) ? 1 : 0);
      idle_before = (m_held < 0) ? 1 : 0;
      manual = 0;
      if (dir == 0) begin
         m_held = -1;
      end else if (m_held < 0 || dir != m_ldir) begin
         m_held = 0; manual = 1; m_ldir = dir;
      end else begin
         m_held++;
         if (m_held >= 250 && (m_held - 250) % 60 == 0) manual = 1;
      end
      m_prev_pos = m_pos;
      if (manual == 1) m_pos = clamp_row(m_pos + dir);
`ifdef PADDLE_AUTOPLAY_EN
      if (press == 1 || (idle_before == 1 && dir != 0)) begin
         m_auto = 0; m_idle = 0;
      end else if (m_auto == 1) begin
         m_since++;
         if (m_since % 60 == 0) begin
            tgt = clamp_row(int'(ball_y) - 1);
            if (m_pos < tgt) m_pos++;
            else if (m_pos > tgt) m_pos--;
         end
      end else if (idle_before == 1) begin
         m_idle++;
         if (m_idle == 2000) begin m_auto = 1; m_idle = 0; m_since = 0; end
      end
`else
      if (press == 1 && idle_before == 2) m_auto = 0;
`endif
   endtask

   task automatic tick_step();
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      model_tick();
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0; tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; ball_y = 4'd0;
      model_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (pos !== 4'd6) $display("FAIL reset_pos got=%0d want=6", pos); else n_pass++;
      n_checks++;
      if (hit !== 1'b0) $display("FAIL reset_hit got=%b want=0", hit); else n_pass++;
      n_checks++;
      if (auto !== 1'b0) $display("FAIL reset_auto got=%b want=0", auto); else n_pass++;
      reset = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 100; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'd6 || hit !== 1'b0 || auto !== 1'b0)
            $display("FAIL idle_quiet tick=%0d pos=%0d hit=%b auto=%b want 6/0/0", i, pos, hit, auto);
         else n_pass++;
      end
   endtask

   task automatic test_glitch_and_repeat();
      btn_down = 1'b1;
      for (int i = 1; i <= 5; i++) tick_step();
      btn_down = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'd6) $display("FAIL glitch_pos tick=%0d got=%0d want=6", i, pos); else n_pass++;
      end
      btn_down = 1'b1;
      for (int i = 1; i <= 330; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'(m_pos)) $display("FAIL hold_down tick=%0d got=%0d want=%0d", i, pos, m_pos);
         else n_pass++;
         if (i == 7 || i == 8 || i == 257 || i == 258 || i == 317 || i == 318) begin
            n_checks++;
            if (pos !== 4'((i < 8) ? 6 : (i < 258) ? 7 : (i < 318) ? 8 : 9))
               $display("FAIL repeat_timing tick=%0d got=%0d", i, pos);
            else n_pass++;
         end
      end
      btn_down = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'(m_pos)) $display("FAIL release_down tick=%0d got=%0d want=%0d", i, pos, m_pos);
         else n_pass++;
      end
   endtask

   task automatic test_up_saturate();
      btn_up = 1'b1;
      for (int i = 1; i <= 2000; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'(m_pos)) $display("FAIL hold_up tick=%0d got=%0d want=%0d", i, pos, m_pos);
         else n_pass++;
      end
      n_checks++;
      if (pos !== 4'd0) $display("FAIL up_floor got=%0d want=0", pos); else n_pass++;
      btn_up = 1'b0;
      for (int i = 1; i <= 12; i++) tick_step();
   endtask

   task automatic test_both_pressed();
      int p0;
      p0 = m_pos;
      btn_up = 1'b1; btn_down = 1'b1;
      for (int i = 1; i <= 500; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'(p0)) $display("FAIL both_held tick=%0d got=%0d want=%0d", i, pos, p0);
         else n_pass++;
      end
      btn_up = 1'b0; btn_down = 1'b0;
      for (int i = 1; i <= 12; i++) tick_step();
   endtask

   task automatic test_reset_mid_hold();
      btn_down = 1'b1;
      for (int i = 1; i <= 30; i++) tick_step();
      reset = 1'b0;
      #1;
      n_checks++;
      if (pos !== 4'd6 || hit !== 1'b0 || auto !== 1'b0)
         $display("FAIL midhold_reset pos=%0d hit=%b auto=%b want 6/0/0", pos, hit, auto);
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      for (int i = 1; i <= 8; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'((i < 8) ? 6 : 7)) $display("FAIL redebounce tick=%0d got=%0d", i, pos);
         else n_pass++;
      end
      btn_down = 1'b0;
      for (int i = 1; i <= 12; i++) tick_step();
      pulse_reset();
   endtask

   task automatic test_hit_sweep();
      int prev_b;
      prev_b = int'(ball_y);
      for (int b = 0; b < 16; b++) begin
         ball_y = 4'(b);
         #1;
         n_checks++;
         if (hit !== exp_hit(6, prev_b)) $display("FAIL hit_early ball=%0d got=%b want=%b", b, hit, exp_hit(6, prev_b));
         else n_pass++;
         @(negedge clk);
         n_checks++;
         if (hit !== exp_hit(6, b)) $display("FAIL hit_sweep ball=%0d got=%b want=%b", b, hit, exp_hit(6, b));
         else n_pass++;
         prev_b = b;
      end
   endtask

   task automatic test_random();
      int done, combo, len;
      done = 0;
      while (done < 1500) begin
         combo = $urandom_range(0, 3);
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(150, 400) : $urandom_range(1, 14);
         btn_up = (combo & 1) != 0;
         btn_down = (combo & 2) != 0;
         for (int j = 0; j < len; j++) begin
            ball_y = 4'($urandom_range(0, 15));
            tick_step();
            done++;
            n_checks++;
            if (pos !== 4'(m_pos) || auto !== 1'(m_auto) || hit !== exp_hit(m_prev_pos, int'(ball_y)))
               $display("FAIL random tick=%0d pos=%0d/%0d auto=%b/%0d hit=%b/%b", done, pos, m_pos,
                        auto, m_auto, hit, exp_hit(m_prev_pos, int'(ball_y)));
            else n_pass++;
         end
      end
      btn_up = 1'b0; btn_down = 1'b0;
   endtask

`ifdef PADDLE_AUTOPLAY_EN
   task automatic test_autoplay();
      pulse_reset();
      ball_y = 4'd15;
      for (int i = 1; i <= 2430; i++) begin
         tick_step();
         n_checks++;
         if (pos !== 4'(m_pos) || auto !== 1'(m_auto))
            $display("FAIL autoplay tick=%0d pos=%0d/%0d auto=%b/%0d", i, pos, m_pos, auto, m_auto);
         else n_pass++;
         if (i == 1999 || i == 2000) begin
            n_checks++;
            if (auto !== ((i == 2000) ? 1'b1 : 1'b0)) $display("FAIL auto_engage tick=%0d got=%b", i, auto);
            else n_pass++;
         end
         if (i == 2060) begin
            n_checks++;
            if (pos !== 4'd7) $display("FAIL auto_first_step got=%0d want=7", pos); else n_pass++;
         end
      end
      n_checks++;
      if (pos !== 4'd13) $display("FAIL auto_track_end got=%0d want=13", pos); else n_pass++;
      btn_up = 1'b1;
      for (int i = 1; i <= 8; i++) tick_step();
      n_checks++;
      if (auto !== 1'b0 || pos !== 4'd12)
         $display("FAIL auto_takeover auto=%b pos=%0d want 0/12", auto, pos);
      else n_pass++;
      btn_up = 1'b0;
      for (int i = 1; i <= 12; i++) tick_step();
   endtask
`endif

   initial begin
      #900000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      test_reset();
      test_glitch_and_repeat();
      test_up_saturate();
      test_both_pressed();
      test_reset_mid_hold();
      test_hit_sweep();
      test_random();
`ifdef PADDLE_AUTOPLAY_EN
      test_autoplay();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
